// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: run/done/fault FSM, LUT-driven
// absolute/relative branches, and call/return through a small hardware return stack.
module pc_sequencer #(
  parameter int D  = 10,
  parameter int SD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         br_en,
  input  logic         br_rel,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [3:0]   br_idx,
  input  logic [D-1:0] lut_target,
  output logic [3:0]   lut_addr,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         err
);

  localparam int SPW = $clog2(SD) + 1;
  localparam int IW  = SPW - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   pc_nxt;
  logic [SPW-1:0] sp, sp_nxt, sp_m1;
  logic [D-1:0]   stack [SD];
  logic           push;
  logic [D-1:0]   pc_inc;

  assign lut_addr = br_idx;
  assign pc_inc   = prog_ctr + D'(1);
  assign sp_m1    = sp - SPW'(1);

  // Next-state decode; strobes below the highest-priority active one are dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    sp_nxt    = sp;
    push      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          sp_nxt    = '0;
        end
      end
      RUN: begin
        if (stall) begin
          state_nxt = RUN;
        end else if (halt) begin
          state_nxt = DONE;
        end else if (ret_en) begin
          if (sp == '0) begin
            state_nxt = FAULT;
          end else begin
            sp_nxt = sp_m1;
            pc_nxt = stack[sp_m1[IW-1:0]];
          end
        end else if (call_en) begin
          if (sp == SPW'(SD)) begin
            state_nxt = FAULT;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SPW'(1);
            pc_nxt = lut_target;
          end
        end else if (br_en) begin
          pc_nxt = br_rel ? (prog_ctr + lut_target) : lut_target;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      sp       <= '0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      sp       <= sp_nxt;
    end
  end

  // Return stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack[sp[IW-1:0]] <= pc_inc;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign err     = (state == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: bench-side LUT, linear steps, hand-computed expectations.
module tb_pc_sequencer;

  localparam int D = 10;

  logic         clk = 1'b0;
  logic         reset, start, stall, halt, br_en, br_rel, call_en, ret_en;
  logic [3:0]   br_idx, lut_addr;
  logic [D-1:0] lut_target, prog_ctr;
  logic         running, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(D), .SD(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_en(br_en), .br_rel(br_rel), .call_en(call_en), .ret_en(ret_en),
    .br_idx(br_idx), .lut_target(lut_target), .lut_addr(lut_addr),
    .prog_ctr(prog_ctr), .running(running), .done(done), .err(err)
  );

  // Branch-target LUT model driven from the DUT's lut_addr.
  always_comb begin
    lut_target = '0;
    case (lut_addr)
      4'd2: lut_target = 10'd80;
      4'd3: lut_target = 10'd1020;
      4'd4: lut_target = 10'd1023;
      4'd5: lut_target = 10'd30;
      4'd7: lut_target = 10'd1019;
      4'd9: lut_target = 10'd20;
      default: lut_target = '0;
    endcase
  end

  task automatic applyStimulus(input logic s, input logic st, input logic h,
                               input logic be, input logic br, input logic ce,
                               input logic re, input logic [3:0] idx);
    start = s; stall = st; halt = h; br_en = be; br_rel = br;
    call_en = ce; ret_en = re; br_idx = idx;
    @(posedge clk);
    #1;
    start = 0; stall = 0; halt = 0; br_en = 0; br_rel = 0;
    call_en = 0; ret_en = 0; br_idx = '0;
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [D-1:0] exp_pc,
                             input logic exp_run, input logic exp_done,
                             input logic exp_err);
    checks++;
    assert (prog_ctr === exp_pc) else begin
      errors++;
      $error("[TB] FAIL %s prog_ctr: observed %0d expected %0d", tag, prog_ctr, exp_pc);
    end
    checks++;
    assert ({running, done, err} === {exp_run, exp_done, exp_err}) else begin
      errors++;
      $error("[TB] FAIL %s state run/done/err: observed %b%b%b expected %b%b%b",
             tag, running, done, err, exp_run, exp_done, exp_err);
    end
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; halt = 0; br_en = 0; br_rel = 0;
    call_en = 0; ret_en = 0; br_idx = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    checkOutput("reset", 10'd0, 0, 0, 0);
    checks++;
    br_idx = 4'd9; #1;
    assert (lut_addr === 4'd9) else begin
      errors++;
      $error("[TB] FAIL lut_addr: observed %0d expected 9", lut_addr);
    end
    br_idx = '0;
    idleStep();
    checkOutput("idle_hold", 10'd0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("start", 10'd0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      idleStep();
      checkOutput("incr", D'(i), 1, 0, 0);
    end

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd2);
    checkOutput("br_abs", 10'd80, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'd7);
    checkOutput("br_rel_neg", 10'd75, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd3);
    checkOutput("br_abs_1020", 10'd1020, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 4'd9);
    checkOutput("br_rel_wrap", 10'd16, 1, 0, 0);

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd5);
    checkOutput("br_abs_30", 10'd30, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd9);
    checkOutput("call", 10'd20, 1, 0, 0);
    for (int i = 21; i <= 25; i++) begin
      idleStep();
      checkOutput("in_sub", D'(i), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("ret", 10'd31, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 4'd9);
    checkOutput("call_over_br", 10'd20, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("ret_after_call_br", 10'd32, 1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd2);
      checkOutput("nested_call", 10'd80, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd9);
    checkOutput("overflow_fault", 10'd80, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("fault_ignores_start", 10'd80, 0, 0, 1);
    reset = 1;
    idleStep();
    reset = 0;
    checkOutput("fault_reset", 10'd0, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    idleStep();
    checkOutput("pre_underflow", 10'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("underflow_fault", 10'd1, 0, 0, 1);
    reset = 1;
    idleStep();
    reset = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 7; i++) idleStep();
    checkOutput("pc7", 10'd7, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 1, 0, 4'd2);
      checkOutput("stall_halt", 10'd7, 1, 0, 0);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 4'd0);
    checkOutput("halt_done", 10'd7, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd2);
    checkOutput("done_hold", 10'd7, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0);
    checkOutput("restart", 10'd0, 1, 0, 0);

    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd4);
    checkOutput("pc_max", 10'd1023, 1, 0, 0);
    idleStep();
    checkOutput("incr_wrap", 10'd0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd4);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd2);
    checkOutput("call_at_max", 10'd80, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checkOutput("ret_wrap", 10'd0, 1, 0, 0);

    idleStep();
    reset = 1;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 4'd2);
    reset = 0;
    checkOutput("reset_over_br", 10'd0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
